mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single DPI-backed physical memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Each requester has a valid/ready request channel and a valid/ready response channel.
- The block serialises them to one outstanding memory transaction.
- It holds mem_en for a configurable number of cycles to model access latency.

Parameters:
- LATENCY, 1: cycles mem_en is held per access; must be >= 1 (0 illegal).
- FAIR, 1: 1 = round-robin between IFU and LSU; 0 = fixed priority, LSU wins.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ifu_req_valid  in  1  IFU fetch request valid.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  32  fetch address.
- ifu_resp_valid  out  1  fetch data valid.
- ifu_resp_ready  in  1  IFU consumes response.
- ifu_rdata  out  32  fetched word.
- lsu_req_valid  in  1  LSU request valid.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_wr  in  1  1 = write, 0 = read.
- lsu_addr  in  32  access address.
- lsu_wdata  in  32  write data.
- lsu_wstrb  in  4  byte write mask.
- lsu_resp_valid  out  1  LSU response valid (read data or write ack).
- lsu_resp_ready  in  1  LSU consumes response.
- lsu_rdata  out  32  load data; 0 for write acks.
- mem_en  out  1  memory access enable.
- mem_wr  out  1  1 = write, 0 = read.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_wstrb  out  4  memory byte mask.
- mem_rdata  in  32  memory read data, combinational w.r.t. mem_addr/mem_en.

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE, counter = 0, owner = none.
  - last_grant = IFU, so under FAIR=1 the LSU wins the first conflict.
  - All outputs 0, including ifu_rdata/lsu_rdata.
  - Reset mid-ACCESS drops mem_en immediately, aborts the transaction and produces no response.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Winner selection: the sole valid requester wins.
  - If both are valid: FAIR=1 grants the requester that was not last_grant; FAIR=0 grants the LSU.
  - The winner's req_ready is asserted combinationally; the loser's req_ready = 0.
  - No valid requester: both req_ready = 0.
  - On valid&&ready:
    - Register addr, wr (forced 0 for IFU), wdata, wstrb (0 for IFU) and owner.
    - Set counter = LATENCY-1 and go to ACCESS.
- ACCESS:
  - mem_en = 1; mem_wr/addr/wdata/wstrb are driven from registers.
  - Both req_ready = 0.
  - counter != 0: decrement.
  - counter == 0:
    - For reads, capture mem_rdata into the owner's rdata register; for writes, the LSU rdata register loads 0.
    - Go to RESP.
- Outside ACCESS: mem_en, mem_wr, mem_addr, mem_wdata and mem_wstrb are all 0, so the DPI side never fires spuriously.
- RESP:
  - The owner's resp_valid = 1; the other requester's resp_valid = 0.
  - Hold until owner resp_ready = 1, then set last_grant = owner and go to IDLE.
  - Backpressure of any length is legal; rdata stays stable throughout.
- rdata outputs retain their last captured value after the response completes.
- Latency: request handshake at cycle T → mem_en high T+1..T+LATENCY → resp_valid from T+LATENCY+1. Minimum transaction = LATENCY+2 cycles.
- A requester dropping valid before handshake is legal: no grant and no state change.
- Requesters must hold request fields stable while valid && !ready.
- The arbiter samples request fields only at the handshake; later changes are ignored.
- Only one transaction is outstanding; a new request while in ACCESS/RESP waits in IDLE arbitration.

Test Plan:
- IFU-only read, LATENCY=1: ifu_addr=0x80000000, memory returns 0x00000413 → ifu_req_ready same cycle; mem_en high exactly 1 cycle with mem_wr=0; ifu_resp_valid next cycle with ifu_rdata=0x00000413.
- LSU write, LATENCY=3: addr=0x80001000, wdata=0xDEADBEEF, wstrb=0x3 → mem_en high 3 cycles with mem_wr=1, mem_wstrb=0x3; then lsu_resp_valid with lsu_rdata=0.
- Simultaneous requests, FAIR=1, repeated 4 times from reset: grants LSU, IFU, LSU, IFU. With FAIR=0: LSU all 4 times while LSU stays valid.
- Response backpressure: hold lsu_resp_ready=0 for 5 cycles after a read of 0x12345678 → lsu_resp_valid and lsu_rdata=0x12345678 stable for 5 cycles; ifu_req_ready stays 0; IFU is granted the cycle after the LSU handshake.
- Reset asserted during ACCESS (LATENCY=4, 2nd cycle) → mem_en=0 asynchronously; no resp_valid after release; the next IFU request completes normally.
- Idle check: no valid requests for 10 cycles → mem_en and all mem_* outputs 0; no req_ready or resp_valid asserted.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the IFU (read-only) and the
// LSU (read/write). One transaction is outstanding at a time, mem_en is held
// for LATENCY cycles, and the response is held until the owner accepts it.
// LATENCY must be >= 1.
module mem_arbiter #(
  parameter int LATENCY = 1,
  parameter bit FAIR    = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  // IFU request / response
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  input  logic        ifu_resp_ready,
  output logic [31:0] ifu_rdata,
  // LSU request / response
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic        lsu_wr,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wstrb,
  output logic        lsu_resp_valid,
  input  logic        lsu_resp_ready,
  output logic [31:0] lsu_rdata,
  // memory port
  output logic        mem_en,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IFU, OWN_LSU} owner_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mreq_t;

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        last_lsu_q, last_lsu_d;   // 0 = IFU was granted last
  mreq_t       req_q, req_d;
  logic [31:0] ifu_rdata_q, ifu_rdata_d;
  logic [31:0] lsu_rdata_q, lsu_rdata_d;
  logic        grant_lsu;

  // LSU wins when alone, under fixed priority, or when IFU had the last turn
  assign grant_lsu = lsu_req_valid && (!ifu_req_valid || !FAIR || !last_lsu_q);

  assign ifu_rdata = ifu_rdata_q;
  assign lsu_rdata = lsu_rdata_q;

  // State, capture registers; reset aborts any access in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      cnt_q       <= '0;
      last_lsu_q  <= 1'b0;
      req_q       <= '0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      last_lsu_q  <= last_lsu_d;
      req_q       <= req_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
    end
  end

  // Next-state, arbitration and output decode; memory port is zero unless in ACCESS
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    cnt_d          = cnt_q;
    last_lsu_d     = last_lsu_q;
    req_d          = req_q;
    ifu_rdata_d    = ifu_rdata_q;
    lsu_rdata_d    = lsu_rdata_q;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    mem_en         = 1'b0;
    mem_wr         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_wstrb      = '0;

    case (state_q)
      IDLE: begin
        ifu_req_ready = ifu_req_valid && !grant_lsu;
        lsu_req_ready = grant_lsu;
        if (grant_lsu) begin
          req_d.wr    = lsu_wr;
          req_d.addr  = lsu_addr;
          req_d.wdata = lsu_wdata;
          req_d.wstrb = lsu_wstrb;
          owner_d     = OWN_LSU;
          cnt_d       = CW'(LATENCY - 1);
          state_d     = ACCESS;
        end else if (ifu_req_valid) begin
          req_d.wr    = 1'b0;
          req_d.addr  = ifu_addr;
          req_d.wdata = '0;
          req_d.wstrb = '0;
          owner_d     = OWN_IFU;
          cnt_d       = CW'(LATENCY - 1);
          state_d     = ACCESS;
        end
      end

      ACCESS: begin
        mem_en    = 1'b1;
        mem_wr    = req_q.wr;
        mem_addr  = req_q.addr;
        mem_wdata = req_q.wdata;
        mem_wstrb = req_q.wstrb;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          if (owner_q == OWN_LSU) lsu_rdata_d = req_q.wr ? 32'h0 : mem_rdata;
          else                    ifu_rdata_d = mem_rdata;
          state_d = RESP;
        end
      end

      RESP: begin
        if (owner_q == OWN_LSU) begin
          lsu_resp_valid = 1'b1;
          if (lsu_resp_ready) begin
            last_lsu_d = 1'b1;
            owner_d    = OWN_NONE;
            state_d    = IDLE;
          end
        end else begin
          ifu_resp_valid = 1'b1;
          if (ifu_resp_ready) begin
            last_lsu_d = 1'b0;
            owner_d    = OWN_NONE;
            state_d    = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
